// File: rtl/swipt_pkg.sv
// Shared constants and helpers for the SWIPT receive front end.
package swipt_pkg;

  localparam int ADC_W       = 12;
  localparam int ADC_MAX     = (1 << ADC_W) - 1;
  localparam int THRESH_DEF  = 2048;
  localparam int HYST_DEF    = 64;
  localparam int TIMEOUT_DEF = 1023;
  localparam int TO_W_DEF    = 10;

  // Clamp a threshold into the representable sample range [0, hi].
  function automatic int sat_clip(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/swipt_rx_frontend_hb_monitor.sv
// Heartbeat synchroniser, any-edge detector and timeout watchdog producing the link-alive flag.
// Latency: toggle to alive 4 clk edges; alive drops TIMEOUT+1 edges after the edge-detect edge. No backpressure.
module hb_monitor
  import swipt_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TO_W    = TO_W_DEF
) (
  input  logic clk,
  input  logic nrst,
  input  logic heartbeat_in,
  output logic alive,
  output logic alive_nxt
);

  localparam logic [TO_W-1:0] CNT_TO = TO_W'(TIMEOUT);

  logic            hb_s1;
  logic            hb_s2;
  logic            hb_d;
  logic            hb_edge;
  logic [1:0]      warm;
  logic [TO_W-1:0] cnt;
  logic [TO_W-1:0] cnt_nxt;

  // Next-state alive is exported so the comparator gates on the same edge alive falls.
  always_comb begin
    cnt_nxt   = cnt;
    alive_nxt = alive;
    if (hb_edge) begin
      cnt_nxt   = '0;
      alive_nxt = 1'b1;
    end else begin
      if (cnt != CNT_TO) cnt_nxt = cnt + TO_W'(1);
      if (cnt_nxt == CNT_TO) alive_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      hb_s1   <= 1'b0;
      hb_s2   <= 1'b0;
      hb_d    <= 1'b0;
      hb_edge <= 1'b0;
      warm    <= 2'd0;
      cnt     <= '0;
      alive   <= 1'b0;
    end else begin
      hb_s1 <= heartbeat_in;
      hb_s2 <= hb_s1;
      hb_d  <= hb_s2;
      // Ignore edges until the cleared chain has refilled, so a heartbeat held high is not an edge.
      if (warm != 2'd3) warm <= warm + 2'd1;
      hb_edge <= (warm == 2'd3) && (hb_s2 != hb_d);
      cnt     <= cnt_nxt;
      alive   <= alive_nxt;
    end
  end

endmodule

// File: rtl/swipt_rx_frontend.sv
// SWIPT receive front end: heartbeat liveness plus hysteresis comparator turning ADC samples into a square wave.
// Latency: adc_in to adc_comp 2 clk edges; comparator forced low whenever the link is not alive. No backpressure.
module swipt_rx_frontend #(
  parameter int ADC_W   = swipt_pkg::ADC_W,
  parameter int THRESH  = swipt_pkg::THRESH_DEF,
  parameter int HYST    = swipt_pkg::HYST_DEF,
  parameter int TIMEOUT = swipt_pkg::TIMEOUT_DEF,
  parameter int TO_W    = swipt_pkg::TO_W_DEF
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             heartbeat_in,
  input  logic [ADC_W-1:0] adc_in,
  output logic             swipt_alive,
  output logic             adc_comp
);
  import swipt_pkg::*;

  localparam int               CODE_MAX = (1 << ADC_W) - 1;
  localparam logic [ADC_W-1:0] CMP_HI   = ADC_W'(sat_clip(THRESH + HYST, CODE_MAX));
  localparam logic [ADC_W-1:0] CMP_LO   = ADC_W'(sat_clip(THRESH - HYST, CODE_MAX));

  logic             alive_nxt;
  logic [ADC_W-1:0] adc_q;

  hb_monitor #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_hb_monitor (
    .clk          (clk),
    .nrst         (nrst),
    .heartbeat_in (heartbeat_in),
    .alive        (swipt_alive),
    .alive_nxt    (alive_nxt)
  );

  // Holding the comparator at 0 while dead means it restarts from the low state when alive returns.
  always_ff @(posedge clk) begin
    if (nrst) begin
      adc_q    <= '0;
      adc_comp <= 1'b0;
    end else begin
      adc_q <= adc_in;
      if (!alive_nxt) adc_comp <= 1'b0;
      else if (!adc_comp && (adc_q >= CMP_HI)) adc_comp <= 1'b1;
      else if (adc_comp && (adc_q < CMP_LO)) adc_comp <= 1'b0;
    end
  end

endmodule

// File: tb/tb_swipt_rx_frontend.sv
// Scoreboarded bench: stimulus queues expected output transitions, a negedge monitor pops and compares them.
module tb_swipt_rx_frontend;

  typedef struct {
    int cyc;
    bit val;
    int tol;
  } ev_t;

  logic        clk;
  logic        nrst;
  logic        heartbeat_in;
  logic [11:0] adc_in;
  logic [11:0] adc_sat;
  logic        alive;
  logic        comp;
  logic        sat_alive;
  logic        sat_comp;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic rst_q  = 1'b0;
  bit armed    = 1'b0;
  logic [3:0] cur;
  logic [3:0] prev = 4'b0000;

  ev_t q_alive[$];
  ev_t q_comp[$];
  ev_t q_scomp[$];
  ev_t q_salive[$];

  bit hb_run  = 1'b1;
  bit hb_done = 1'b0;
  int last_tog;
  int v;
  int base;
  int t2;
  int x;

  swipt_rx_frontend u_dut (
    .clk          (clk),
    .nrst         (nrst),
    .heartbeat_in (heartbeat_in),
    .adc_in       (adc_in),
    .swipt_alive  (alive),
    .adc_comp     (comp)
  );

  swipt_rx_frontend #(.THRESH(4090), .HYST(64)) u_sat (
    .clk          (clk),
    .nrst         (nrst),
    .heartbeat_in (heartbeat_in),
    .adc_in       (adc_sat),
    .swipt_alive  (sat_alive),
    .adc_comp     (sat_comp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= nrst;
  end

  function automatic string sig_name(input int s);
    case (s)
      0: return "swipt_alive";
      1: return "adc_comp";
      2: return "sat_adc_comp";
      default: return "sat_swipt_alive";
    endcase
  endfunction

  task automatic push(input int s, input int c, input bit val, input int tol);
    ev_t e;
    e.cyc = c;
    e.val = val;
    e.tol = tol;
    case (s)
      0: q_alive.push_back(e);
      1: q_comp.push_back(e);
      2: q_scomp.push_back(e);
      default: q_salive.push_back(e);
    endcase
  endtask

  // Alive is shared by both instances, so every alive event is expected on both.
  task automatic push_alive(input int c, input bit val);
    push(0, c, val, 0);
    push(3, c, val, 0);
  endtask

  task automatic check_evt(input int s, input logic val);
    ev_t e;
    bit have;
    have = 1'b0;
    case (s)
      0: if (q_alive.size() > 0) begin e = q_alive.pop_front(); have = 1'b1; end
      1: if (q_comp.size() > 0) begin e = q_comp.pop_front(); have = 1'b1; end
      2: if (q_scomp.size() > 0) begin e = q_scomp.pop_front(); have = 1'b1; end
      default: if (q_salive.size() > 0) begin e = q_salive.pop_front(); have = 1'b1; end
    endcase
    checks++;
    if (!have) begin
      failures++;
      $display("FAIL %s: unexpected transition to %0b at cycle %0d, required no transition",
               sig_name(s), val, cyc);
    end else if ((val !== e.val) || (cyc > e.cyc + e.tol) || (cyc + e.tol < e.cyc)) begin
      failures++;
      $display("FAIL %s: got %0b at cycle %0d, required %0b at cycle %0d (+/-%0d)",
               sig_name(s), val, cyc, e.val, e.cyc, e.tol);
    end
  endtask

  task automatic check_drained(input int s, input int n);
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL %s_pending: %0d expected transitions never seen, required 0", sig_name(s), n);
    end
  endtask

  always @(negedge clk) begin
    cur = {sat_alive, sat_comp, comp, alive};
    if (rst_q === 1'b1) begin
      armed = 1'b1;
      for (int s = 0; s < 4; s++) begin
        checks++;
        if (cur[s] !== 1'b0) begin
          failures++;
          $display("FAIL %s_in_reset: got %b at cycle %0d, required 0", sig_name(s), cur[s], cyc);
        end
      end
      prev = 4'b0000;
    end else if (armed) begin
      for (int s = 0; s < 4; s++)
        if (cur[s] !== prev[s]) check_evt(s, cur[s]);
      prev = cur;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    nrst         = 1'b1;
    heartbeat_in = 1'b0;
    adc_in       = 12'd4095;
    adc_sat      = 12'd4095;

    // Reset with heartbeat toggling and full-scale input; ends with heartbeat held high.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i % 2 == 1) heartbeat_in = ~heartbeat_in;
    end
    nrst    = 1'b0;
    adc_in  = 12'd1900;
    adc_sat = 12'd0;
    repeat (20) @(negedge clk);

    fork
      begin
        heartbeat_in = ~heartbeat_in;
        push_alive(cyc + 4, 1'b1);
        last_tog = cyc;
        while (hb_run) begin
          repeat (90) @(negedge clk);
          if (hb_run) begin
            heartbeat_in = ~heartbeat_in;
            last_tog = cyc;
          end
        end
        hb_done = 1'b1;
      end
    join_none

    repeat (10) @(negedge clk);

    // Ramp 1900 -> 2200 -> 1900: hi threshold 2112, lo threshold 1984.
    for (int k = 0; k <= 600; k++) begin
      v = (k <= 300) ? 1900 + k : 2200 - (k - 300);
      adc_in = v[11:0];
      if (k <= 300 && v == 2112) push(1, cyc + 2, 1'b1, 0);
      if (k > 300 && v == 1983) push(1, cyc + 2, 1'b0, 0);
      @(negedge clk);
    end

    // Sine, 2500-cycle period, +/-1500: first sample >= 2112 is n=17, first < 1984 is n=1268.
    base = cyc;
    for (int p = 0; p < 3; p++) begin
      push(1, base + 2500 * p + 17 + 2, 1'b1, 2);
      push(1, base + 2500 * p + 1268 + 2, 1'b0, 2);
    end
    for (int n = 0; n < 7500; n++) begin
      v = int'(2048.0 + 1500.0 * $sin(2.0 * 3.14159265358979 * real'(n) / 2500.0));
      adc_in = v[11:0];
      @(negedge clk);
    end

    adc_in = 12'd2200;
    push(1, cyc + 2, 1'b1, 0);
    repeat (10) @(negedge clk);

    // Stop the heartbeat: alive and comp drop together TIMEOUT+1 after the edge-detect edge.
    hb_run = 1'b0;
    for (int i = 0; i < 200 && !hb_done; i++) @(negedge clk);
    checks++;
    if (!hb_done) begin
      failures++;
      $display("FAIL hb_stop: heartbeat process still running at cycle %0d, required stopped", cyc);
    end
    push_alive(last_tog + 1027, 1'b0);
    push(1, last_tog + 1027, 1'b0, 0);
    repeat (1100) @(negedge clk);

    // Reacquire: comp rises on the same edge as alive since adc_q is already above hi.
    heartbeat_in = ~heartbeat_in;
    t2 = cyc;
    push_alive(t2 + 4, 1'b1);
    push(1, t2 + 4, 1'b1, 0);
    repeat (10) @(negedge clk);

    // Saturated instance: hi clips to 4095, so 4094 must not trip it.
    adc_sat = 12'd4094;
    repeat (5) @(negedge clk);
    adc_sat = 12'd4095;
    push(2, cyc + 2, 1'b1, 0);

    // Edge lands on the cycle the counter would hit TIMEOUT: alive must stay high.
    while (cyc < t2 + 1023) @(negedge clk);
    heartbeat_in = ~heartbeat_in;
    x = cyc;
    push_alive(x + 1027, 1'b0);
    push(1, x + 1027, 1'b0, 0);
    push(2, x + 1027, 1'b0, 0);
    repeat (1040) @(negedge clk);

    check_drained(0, q_alive.size());
    check_drained(1, q_comp.size());
    check_drained(2, q_scomp.size());
    check_drained(3, q_salive.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/swipt_rx_frontend.md
# swipt_rx_frontend

Receive-side front end of the SWIPT link. It watches the link heartbeat to decide whether the link is alive. It also converts the 12-bit ADC sample stream from the analog network into a clean 1-bit square wave (`adc_comp`) for the downstream PLL. The block sits between the ADC/analog interface and the PLL/transmit controller.

## Interface
Parameters:
- `ADC_W`, 12: ADC sample width.
- `THRESH`, 2048: comparator centre level, unsigned counts.
- `HYST`, 64: half-width of the hysteresis band, counts.
- `TIMEOUT`, 1023: clk cycles without a heartbeat edge before alive drops.
- `TO_W`, 10: timeout counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- `clk`, in, 1: clock, nominal 100 MHz.
- `nrst`, in, 1: reset, synchronous, active-high.
- `heartbeat_in`, in, 1: asynchronous heartbeat toggle from the transmitter, nominal 1.8 µs period.
- `adc_in`, in, ADC_W: unsigned ADC sample, asynchronous to clk but quasi-static.
- `swipt_alive`, out, 1: link-alive flag.
- `adc_comp`, out, 1: hysteresis-comparator output; forced 0 when not alive.

## Operation
Reset:
- Applies while `nrst`=1 at a clk edge.
- Clears `swipt_alive`, `adc_comp`, the synchroniser flops, the timeout counter and the sample register.

Heartbeat:
- Two-flop synchroniser, then a third flop for edge detection.
- Both rising and falling edges count as an edge.

Alive:
- On an edge: counter cleared, `swipt_alive` set to 1.
- Without an edge: counter increments and saturates at TIMEOUT.
- When counter = TIMEOUT: `swipt_alive` cleared.
- Edge and timeout in the same cycle: the edge wins.

Sample path:
- `adc_in` registered every cycle into `adc_q`.

Comparator:
- Thresholds computed in ADC_W+1 bits and saturated to [0, 2^ADC_W−1]:
  - hi = THRESH+HYST
  - lo = THRESH−HYST
- If `adc_comp`=0 and `adc_q` ≥ hi: `adc_comp` goes to 1.
- If `adc_comp`=1 and `adc_q` < lo: `adc_comp` goes to 0.
- Otherwise `adc_comp` holds.

Gating:
- While `swipt_alive`=0, `adc_comp` is held at 0.
- When alive returns, comparator state restarts from 0.

HYST=0 degenerates to a plain comparator: 1 when `adc_q` ≥ THRESH.

## Timing
- Heartbeat toggle to `swipt_alive` rising: 4 clk edges (sync ×2, edge reg, alive reg).
- Last edge to `swipt_alive` falling: TIMEOUT+1 cycles after the edge-detect cycle.
- `adc_in` change to `adc_comp` change: 2 clk edges (`adc_q`, then `adc_comp`).
- `swipt_alive` falling to `adc_comp`=0: same edge as alive falls. Gating uses the next-state alive value.
- Reset mid-operation: all state cleared on that edge.
  - After release, alive needs a fresh heartbeat edge.
  - The synchroniser is reset, so a constant-high heartbeat does not create a spurious edge.
- Outputs are registered; no combinational input-to-output path.

## Structure
- Shared package `swipt_pkg`: `ADC_W`, `ADC_MAX`, default `THRESH`/`HYST`/`TIMEOUT`, and a `hb_state` typedef if an enum is used.
- One natural sub-module: `hb_monitor`. It contains the synchroniser, edge detect, timeout counter and alive flag.
- The comparator and sample register sit in the top module.
- The analog network is a bench-only behavioural model; not part of RTL.

## Test plan
- Reset/idle: `nrst`=1 for 10 cycles with heartbeat toggling and `adc_in`=4095 → `swipt_alive`=0, `adc_comp`=0 throughout.
- Heartbeat acquire/hold: release reset, toggle heartbeat every 90 cycles.
  - `swipt_alive`=1 exactly 4 cycles after the first toggle.
  - `swipt_alive` stays 1 for ≥10 toggles.
- Timeout: stop toggling → `swipt_alive` falls 1024 cycles after the last edge-detect; `adc_comp` falls on the same edge.
- Hysteresis, alive, THRESH=2048, HYST=64, ramp `adc_in` 1900→2200→1900 in steps of 1 per cycle:
  - `adc_comp` rises 2 cycles after `adc_in`=2112.
  - `adc_comp` falls 2 cycles after `adc_in`=1983.
  - Values 1984–2111 cause no toggle.
- Sine input: 40 kHz, 2500-cycle period, amplitude ±1500 around 2048 → square wave, 2500-cycle period, duty 50% ±2 cycles, one transition per half-period.
- Saturation/edge: THRESH=4090, HYST=64 → hi saturates to 4095; `adc_in`=4095 sets `adc_comp`=1; a toggle coincident with the timeout cycle keeps `swipt_alive`=1.
